// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_bus_pkg : shared types and constants for the bus memory responder
// Revision     : 1.0
// ----------------------------------------------------------------------------
package mips_bus_pkg;

  localparam int          BUS_W        = 32;
  localparam int          BE_W         = 4;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/stall_lfsr16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stall_lfsr16 : 16-bit Fibonacci LFSR (taps 16,14,13,11) for stall jitter
// Revision     : 1.0
// ----------------------------------------------------------------------------
module stall_lfsr16
  import mips_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/mips_bus_memory.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_bus_memory : word RAM bus responder with byte lanes and wait states
// Revision        : 1.0
// ----------------------------------------------------------------------------
module mips_bus_memory
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = RESET_VECTOR,
  parameter int          MEM_WORDS    = 4096,
  parameter int          WAIT_STATES  = 0,
  parameter int          RANDOM_STALL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BUS_W-1:0] address,
  input  logic             read,
  input  logic             write,
  input  logic [BUS_W-1:0] writedata,
  input  logic [BE_W-1:0]  byteenable,
  output logic             waitrequest,
  output logic [BUS_W-1:0] readdata,
  output logic             err
);

  localparam int               AW     = $clog2(MEM_WORDS);
  localparam logic [BUS_W-3:0] BASE_W = MEM_BASE[BUS_W-1:2];

  logic [BUS_W-1:0] mem_q [MEM_WORDS];

  state_e           state_q,  state_d;
  logic [4:0]       cnt_q,    cnt_d;
  logic [BUS_W-3:0] addr_q,   addr_d;
  logic [BUS_W-1:0] wdata_q,  wdata_d;
  logic [BE_W-1:0]  be_q,     be_d;
  logic             dir_wr_q, dir_wr_d;
  logic             err_q,    err_d;

  logic [15:0]      lfsr;
  logic             advance;
  logic [4:0]       stall_n;
  logic [BUS_W-3:0] word_in;
  logic [BUS_W-3:0] cmp_word;
  logic [BUS_W-3:0] cmp_off;
  logic [AW-1:0]    cmp_idx;
  logic             in_range;
  logic             cmp_valid;
  logic             cmp_wr;
  logic [BUS_W-1:0] cmp_wdata;
  logic [BE_W-1:0]  cmp_be;
  logic             mem_we;
  logic             unused_ok;

  stall_lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (advance),
    .value   (lfsr)
  );

  assign word_in = address[BUS_W-1:2];
  assign stall_n = 5'(WAIT_STATES) + ((RANDOM_STALL != 0) ? {3'b000, lfsr[1:0]} : 5'd0);

  // In ACK the transfer finishes on the fields captured at acceptance.
  assign cmp_word = (state_q == ACK) ? addr_q : word_in;
  assign cmp_off  = cmp_word - BASE_W;
  assign in_range = (cmp_word >= BASE_W) && (cmp_off < (BUS_W-2)'(MEM_WORDS));
  assign cmp_idx  = cmp_off[AW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    dir_wr_d    = dir_wr_q;
    err_d       = err_q;
    advance     = 1'b0;
    waitrequest = 1'b0;
    cmp_valid   = 1'b0;
    cmp_wr      = write;
    cmp_wdata   = writedata;
    cmp_be      = byteenable;
    case (state_q)
      IDLE: begin
        if (read && write) begin
          err_d = 1'b1;
        end else if (read || write) begin
          advance = 1'b1;
          if (stall_n == 5'd0) begin
            cmp_valid = 1'b1;
          end else begin
            waitrequest = 1'b1;
            addr_d      = word_in;
            wdata_d     = writedata;
            be_d        = byteenable;
            dir_wr_d    = write;
            cnt_d       = stall_n - 5'd1;
            state_d     = (stall_n == 5'd1) ? ACK : STALL;
          end
        end
      end
      STALL: begin
        waitrequest = 1'b1;
        if ((dir_wr_q ? (!write || read) : (!read || write)) || (word_in != addr_q)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        cmp_valid = 1'b1;
        cmp_wr    = dir_wr_q;
        cmp_wdata = wdata_q;
        cmp_be    = be_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cmp_valid && !in_range) begin
      err_d = 1'b1;
    end
    if (reset) begin
      waitrequest = 1'b0;
      cmp_valid   = 1'b0;
    end
  end

  assign mem_we   = cmp_valid && cmp_wr && in_range;
  assign readdata = (cmp_valid && !cmp_wr && in_range) ? mem_q[cmp_idx] : '0;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      dir_wr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      dir_wr_q <= dir_wr_d;
      err_q    <= err_d;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cmp_be[i]) begin
          mem_q[cmp_idx][8*i +: 8] <= cmp_wdata[8*i +: 8];
        end
      end
    end
  end

  assign unused_ok = ^{address[1:0], lfsr[15:2]};

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_memory.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mips_bus_memory : scoreboard bench for three responder configurations
// Revision           : 1.0
// ----------------------------------------------------------------------------
module tb_mips_bus_memory;

  typedef struct {
    int          d;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  rd  = 3'b000;
  logic [2:0]  wr  = 3'b000;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  ben   [3];
  logic [2:0]  wrq;
  logic [31:0] rdq   [3];
  logic [2:0]  errq;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          mcnt[3];
  exp_t        me;

  always #5 clk = ~clk;

  // dut0: no stalls, dut1: three fixed stalls, dut2: LFSR-driven stalls
  mips_bus_memory #(.WAIT_STATES(0), .RANDOM_STALL(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]), .write(wr[0]),
    .writedata(wdata[0]), .byteenable(ben[0]), .waitrequest(wrq[0]),
    .readdata(rdq[0]), .err(errq[0]));
  mips_bus_memory #(.WAIT_STATES(3), .RANDOM_STALL(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]), .write(wr[1]),
    .writedata(wdata[1]), .byteenable(ben[1]), .waitrequest(wrq[1]),
    .readdata(rdq[1]), .err(errq[1]));
  mips_bus_memory #(.WAIT_STATES(0), .RANDOM_STALL(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]), .write(wr[2]),
    .writedata(wdata[2]), .byteenable(ben[2]), .waitrequest(wrq[2]),
    .readdata(rdq[2]), .err(errq[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] erd, input int est);
    exp_t e;
    int   n;
    bit   done;
    e.d = d; e.rdata = erd; e.stall = est;
    sb.push_back(e);
    @(posedge clk); #1;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; ben[d] = be;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (!wrq[d]) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout dut%0d addr=%h waited=%0d cycles", d, a, n);
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  // Monitor: every completing cycle pops one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d] || !(rd[d] || wr[d])) begin
        mcnt[d] = 0;
      end else if (wrq[d]) begin
        mcnt[d]++;
      end else begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion dut%0d actual=1 required=0", d);
        end else begin
          me = sb.pop_front();
          chk($sformatf("dut%0d_owner", d), d, me.d);
          chk($sformatf("dut%0d_readdata", d), rdq[d], me.rdata);
          chk($sformatf("dut%0d_stall", d), mcnt[d], me.stall);
        end
        mcnt[d] = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m [16];
    logic [15:0] l;
    logic [31:0] v, a;
    logic [3:0]  be;
    int          idx;

    for (int d = 0; d < 3; d++) begin
      addr[d] = '0; wdata[d] = '0; ben[d] = '0; mcnt[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_waitreq%0d", d), wrq[d], 0);
      chk($sformatf("reset_readdata%0d", d), rdq[d], 0);
      chk($sformatf("reset_err%0d", d), errq[d], 0);
    end

    // dut0: zero-wait basic, byte lanes, boundaries and error cases
    xfer(0, 0, 1, 32'hBFC00000, 32'h11223344, 4'hF, 32'h0, 0);
    xfer(0, 1, 0, 32'hBFC00000, 32'h0, 4'h0, 32'h11223344, 0);
    xfer(0, 0, 1, 32'hBFC00004, 32'hAABBCCDD, 4'hF, 32'h0, 0);
    xfer(0, 0, 1, 32'hBFC00006, 32'h00000099, 4'h1, 32'h0, 0);
    xfer(0, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 32'hAABBCC99, 0);
    xfer(0, 0, 1, 32'hBFC00004, 32'h12345678, 4'h6, 32'h0, 0);
    xfer(0, 0, 1, 32'hBFC00004, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
    xfer(0, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 32'hAA345699, 0);
    xfer(0, 0, 1, 32'hBFC03FFC, 32'h5A5A0FF0, 4'hF, 32'h0, 0);
    xfer(0, 1, 0, 32'hBFC03FFC, 32'h0, 4'h0, 32'h5A5A0FF0, 0);
    idle(0);
    @(negedge clk);
    chk("dut0_err_clean", errq[0], 0);
    xfer(0, 1, 1, 32'hBFC00000, 32'h0, 4'hF, 32'h0, 0);
    idle(0);
    @(negedge clk);
    chk("dut0_err_rw_both", errq[0], 1);
    xfer(0, 0, 1, 32'hBFC04000, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
    xfer(0, 1, 0, 32'hBFC00000, 32'h0, 4'h0, 32'h11223344, 0);
    idle(0);

    // dut1: three fixed wait states
    xfer(1, 0, 1, 32'hBFC00004, 32'hCAFEF00D, 4'hF, 32'h0, 3);
    xfer(1, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 32'hCAFEF00D, 3);
    idle(1);
    @(negedge clk);
    chk("dut1_err_clean", errq[1], 0);
    xfer(1, 1, 0, 32'h00000000, 32'h0, 4'h0, 32'h0, 3);
    idle(1);
    @(negedge clk);
    chk("dut1_err_range", errq[1], 1);
    xfer(1, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 32'hCAFEF00D, 3);
    idle(1);

    // reset lands in the middle of a stalled write
    @(posedge clk); #1;
    wr[1] = 1'b1; addr[1] = 32'hBFC00004; wdata[1] = 32'h0; ben[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1; wr[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("dut1_reset_waitreq", wrq[1], 0);
    chk("dut1_reset_err", errq[1], 0);
    xfer(1, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 32'hCAFEF00D, 3);
    idle(1);

    // write request withdrawn during stall aborts the transfer
    @(posedge clk); #1;
    wr[1] = 1'b1; addr[1] = 32'hBFC00004; wdata[1] = 32'hDEADBEEF; ben[1] = 4'hF;
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("dut1_abort_err", errq[1], 1);
    xfer(1, 1, 0, 32'hBFC00004, 32'h0, 4'h0, 32'hCAFEF00D, 3);
    idle(1);

    // dut2: LFSR-driven stalls against a reference model
    l = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      xfer(2, 0, 1, 32'hBFC00100 + 32'(4*i), v, 4'hF, 32'h0, int'(l[1:0]));
      m[i] = v;
      l = lfsr_next(l);
    end
    for (int k = 0; k < 1000; k++) begin
      idx = $urandom_range(0, 15);
      v   = $urandom;
      be  = 4'($urandom_range(0, 15));
      a   = 32'hBFC00100 + 32'(4*idx);
      if ($urandom_range(0, 1) == 1) begin
        xfer(2, 1, 0, a, v, be, m[idx], int'(l[1:0]));
      end else begin
        xfer(2, 0, 1, a, v, be, 32'h0, int'(l[1:0]));
        m[idx] = merge(m[idx], v, be);
      end
      l = lfsr_next(l);
    end
    idle(2);
    @(negedge clk);
    chk("dut2_err_clean", errq[2], 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
